// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} loader_state_t;

  localparam int LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/uart_boot_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags expiry at TIMEOUT_CYCLES-1.
// Latency: expired_o is combinational from the count register.
// Backpressure: none; clr_i takes priority over counting.
module uart_boot_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i || !en_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses SYNC/count/words/checksum boot frames from a UART byte stream into instruction memory.
// Latency: memWe pulses one cycle after the 4th byte of each word. Backpressure: none (rxValid is a pulse).
// Build option: UART_BOOT_LOADER_CHECKSUM_EN enables the XOR checksum check.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 12,
  parameter int          BASE_ADDR      = 0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic                  cpuHold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           MAX_WORDS = 32'd1 << ADDR_WIDTH;
  localparam logic [1:0]            LAST_BYTE = 2'(LOADER_WORD_BYTES - 1);

  loader_state_t         state_q;
  logic [7:0]            len_lo_q;
  logic [15:0]           words_left_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           word_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  err_q;

  logic [15:0] len_d;
  logic [31:0] word_d;
  logic        in_frame;
  logic        tmo_expired;
  logic        csum_ok;

  assign len_d    = {rxData, len_lo_q};
  assign word_d   = {rxData, word_q};
  assign in_frame = (state_q == LEN0) || (state_q == LEN1) ||
                    (state_q == DATA) || (state_q == CSUM);

  uart_boot_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (rxValid),
    .en_i      (in_frame),
    .expired_o (tmo_expired)
  );

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  assign csum_ok = (rxData == csum_q);

  // The SYNC byte always arrives in IDLE or ERR, so clearing there excludes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (rxValid) begin
      if ((state_q == IDLE) || (state_q == ERR)) begin
        csum_q <= '0;
      end else if ((state_q == LEN0) || (state_q == LEN1) || (state_q == DATA)) begin
        csum_q <= csum_q ^ rxData;
      end
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= BASE;
      wdata_q      <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Address advances the cycle after each write strobe so it is stable during the write.
      if (state_q == ERR) begin
        addr_q <= BASE;
      end else if (we_q) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end

      if (rxValid) begin
        unique case (state_q)
          IDLE: begin
            if (rxData == SYNC_BYTE) state_q <= LEN0;
          end
          LEN0: begin
            len_lo_q <= rxData;
            state_q  <= LEN1;
          end
          LEN1: begin
            words_left_q <= len_d;
            byte_idx_q   <= '0;
            if (len_d == 16'd0) begin
              state_q <= CSUM;
            end else if (32'(len_d) > MAX_WORDS) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            word_q     <= word_d[31:8];
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == LAST_BYTE) begin
              we_q         <= 1'b1;
              wdata_q      <= word_d;
              words_left_q <= words_left_q - 16'd1;
              if (words_left_q == 16'd1) state_q <= CSUM;
            end
          end
          CSUM: begin
            if (csum_ok) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
          DONE: begin
          end
          ERR: begin
            if (rxData == SYNC_BYTE) begin
              state_q <= LEN0;
              err_q   <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end else if (tmo_expired) begin
        state_q <= ERR;
        err_q   <= 1'b1;
      end
    end
  end

  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign cpuHold  = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule
